alu_mul_sequencer: RTL and testbench

Multi-cycle sequencer that computes the low 64 bits of op_a * op_b (RV64 MUL semantics) by shift-and-add iterations through the shared 64-bit ALU. It owns the ALU operand and control inputs while busy, and drives the ALU for addition only (ALU control 4'b0000). The block sits beside the execute stage and is started by a one-cycle start pulse. It reports completion with a one-cycle done pulse and a held product register.

---
 rtl/alu_mul_sequencer.sv | 89 ++++++++
 tb/tb_alu_mul_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier sequencer producing the low WIDTH bits of op_a*op_b
// by borrowing an external adder (ALU control 4'b0000) while busy.
module alu_mul_sequencer #(
  parameter int WIDTH      = 64,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] m, q, acc, acc_next;
  logic [CW-1:0]    cnt;
  logic             last;

  always_comb begin
    acc_next   = q[0] ? alu_result : acc;
    // Early exit looks at the multiplier bits that remain after this iteration.
    last       = (cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && (q[WIDTH-1:1] == '0));
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = 4'b0000;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy  = 1'b1;
        alu_a = acc;
        alu_b = m;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m   <= op_a;
          q   <= op_b;
          acc <= '0;
          cnt <= '0;
        end
        RUN: begin
          acc <= acc_next;
          m   <= m << 1;
          q   <= q >> 1;
          cnt <= cnt + 1'b1;
          if (last) product <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one instance per EARLY_EXIT setting,
// each wired to a behavioural adder-only ALU.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [63:0] op_a, op_b;
  logic        busy0, busy1, done0, done1;
  logic [63:0] product0, product1;
  logic [63:0] alu_a0, alu_b0, alu_a1, alu_b1;
  logic [3:0]  alu_ctrl0, alu_ctrl1;
  logic [63:0] alu_result0, alu_result1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign alu_result0 = (alu_ctrl0 == 4'b0000) ? alu_a0 + alu_b0 : '0;
  assign alu_result1 = (alu_ctrl1 == 4'b0000) ? alu_a1 + alu_b1 : '0;

  alu_mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op_a(op_a), .op_b(op_b),
    .busy(busy0), .done(done0), .product(product0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_ctrl(alu_ctrl0), .alu_result(alu_result0)
  );

  alu_mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(op_a), .op_b(op_b),
    .busy(busy1), .done(done1), .product(product1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_ctrl1), .alu_result(alu_result1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an operation in the current cycle T; cycle offsets are relative to T.
  // inj > 0 pulses a spurious start (100*100) in cycle T+inj.
  task automatic do_op(input bit sel, input logic [63:0] a, input logic [63:0] b,
                       input int inj, input int exp_lat, input logic [63:0] exp_prod,
                       input string tag);
    int   done_at = 0;
    int   pulses  = 0;
    logic ctrl_bad = 1'b0;
    logic busy_bad = 1'b0;
    logic idle_ok  = 1'b0;
    op_a = a;
    op_b = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    step();
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      logic d, bz;
      logic [3:0] ctl;
      d   = sel ? done1 : done0;
      bz  = sel ? busy1 : busy0;
      ctl = sel ? alu_ctrl1 : alu_ctrl0;
      if (d) begin
        pulses++;
        if (done_at == 0) done_at = i;
      end
      if (i <= exp_lat && !bz) busy_bad = 1'b1;
      if (ctl !== 4'b0000) ctrl_bad = 1'b1;
      if (done_at != 0 && i == done_at + 1) begin
        idle_ok = !bz && !d;
        break;
      end
      if (i == inj) begin
        op_a = 64'd100;
        op_b = 64'd100;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      step();
      start0 = 1'b0;
      start1 = 1'b0;
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_lat));
    check({tag, "_done_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_product"}, sel ? product1 : product0, exp_prod);
    check({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
    check({tag, "_alu_ctrl"}, 64'(ctrl_bad), 64'd0);
    check({tag, "_idle_after"}, 64'(idle_ok), 64'd1);
  endtask

  initial begin
    int pulses;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    op_a   = '0;
    op_b   = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_done0", 64'(done0), 64'd0);
    check("rst_product0", product0, 64'd0);
    check("rst_alu_a0", alu_a0, 64'd0);
    check("rst_alu_b0", alu_b0, 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_product1", product1, 64'd0);

    do_op(1'b0, 64'd3, 64'd5, 0, 65, 64'd15, "full_3x5");
    do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 0, 65, 64'hFFFF_FFFF_FFFF_FFF9, "full_neg1x7");
    do_op(1'b0, 64'h8000_0000_0000_0000, 64'd2, 0, 65, 64'd0, "full_wrap");

    do_op(1'b1, 64'd9, 64'd5, 0, 4, 64'd45, "early_9x5");
    do_op(1'b1, 64'd123, 64'd0, 0, 2, 64'd0, "early_b0");
    do_op(1'b1, 64'd3, 64'h8000_0000_0000_0000, 0, 65, 64'h8000_0000_0000_0000, "early_msb");

    // Spurious start mid-run, then a start in the cycle right after done.
    do_op(1'b0, 64'd3, 64'd5, 10, 65, 64'd15, "ignore_busy");
    do_op(1'b0, 64'd6, 64'd7, 0, 65, 64'd42, "back2back");

    // Reset for one cycle at T+20 aborts the operation.
    op_a   = 64'd11;
    op_b   = 64'd13;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 1; i < 20; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_done", 64'(done0), 64'd0);
    check("abort_product", product0, 64'd0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      if (done0) pulses++;
      step();
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    do_op(1'b0, 64'd11, 64'd13, 0, 65, 64'd143, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
